// File: rtl/riscv_test_monitor_pkg.sv
// Shared types for the RISC-V data-bus pass/fail monitor: FSM state encoding
// and the store-log record layout.
package riscv_test_pkg;

    localparam int unsigned STORE_XLEN = 32;

    typedef enum logic [1:0] {
        MON_RUN     = 2'b00,
        MON_PASS    = 2'b01,
        MON_FAIL    = 2'b10,
        MON_TIMEOUT = 2'b11
    } mon_state_t;

    typedef struct packed {
        logic [STORE_XLEN-1:0] adr;
        logic [STORE_XLEN-1:0] data;
    } store_rec_t;

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Data-memory store tap between the single-cycle core (master) and the monitor (slave).
interface riscv_test_monitor_if #(
    parameter int unsigned XLEN = 32
);

    logic            MemWrite;
    logic [XLEN-1:0] DataAdr;
    logic [XLEN-1:0] WriteData;

    modport master (output MemWrite, DataAdr, WriteData);
    modport slave  (input  MemWrite, DataAdr, WriteData);

endinterface

// File: rtl/riscv_test_monitor_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for the single-cycle core's store bus: tohost completion
// check, cycle watchdog and a FIFO log of ordinary stores.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'd100,
    parameter logic [XLEN-1:0] PASS_DATA   = 32'd25,
    parameter int unsigned     TIMEOUT     = 500,
    parameter int unsigned     LOG_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_test_monitor_if.slave  bus,
    input  logic                 log_pop,
    output logic                 log_valid,
    output logic [XLEN-1:0]      log_adr,
    output logic [XLEN-1:0]      log_data,
    output logic                 log_overflow,
    output logic [1:0]           state,
    output logic                 done,
    output logic [31:0]          cycle_count,
    output logic [31:0]          store_count
);

    mon_state_t  state_q, state_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] store_q, store_d;
    logic        ovf_q, ovf_d;

    logic        running;
    logic        tohost;
    logic        log_push;
    logic        timeout_hit;
    logic        log_full;
    logic        log_empty;
    store_rec_t  rec_in;
    store_rec_t  rec_out;

    assign running     = (state_q == MON_RUN);
    assign tohost      = bus.MemWrite && (bus.DataAdr == TOHOST_ADDR);
    assign log_push    = running && bus.MemWrite && !tohost;
    assign timeout_hit = (TIMEOUT != 0) && (cycle_q == 32'(TIMEOUT - 1));

    assign rec_in.adr  = STORE_XLEN'(bus.DataAdr);
    assign rec_in.data = STORE_XLEN'(bus.WriteData);

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        store_d = store_q;
        ovf_d   = ovf_q;
        if (running) begin
            cycle_d = cycle_q + 32'd1;
            // A tohost store outranks a watchdog expiry in the same cycle.
            if (tohost) begin
                state_d = (bus.WriteData == PASS_DATA) ? MON_PASS : MON_FAIL;
            end else if (timeout_hit) begin
                state_d = MON_TIMEOUT;
            end
            if (log_push) begin
                store_d = store_q + 32'd1;
                if (log_full && !log_pop) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MON_RUN;
            cycle_q <= '0;
            store_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            store_q <= store_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(store_rec_t)),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk   (clk),
        .rst   (reset),
        .push  (log_push),
        .pop   (log_pop),
        .din   (rec_in),
        .dout  (rec_out),
        .full  (log_full),
        .empty (log_empty)
    );

    assign log_valid    = !log_empty;
    assign log_adr      = XLEN'(rec_out.adr);
    assign log_data     = XLEN'(rec_out.data);
    assign log_overflow = ovf_q;
    assign state        = state_q;
    assign done         = (state_q != MON_RUN);
    assign cycle_count  = cycle_q;
    assign store_count  = store_q;

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesisable pass/fail monitor for the RISC-V single-cycle core's data-memory bus. It sits beside `riscvsc_top` and taps its `WriteData`, `DataAdr` and `MemWrite` outputs. It replaces the fixed free-running stimulus and hard stop used by current benches with three things: a tohost-style completion check, a cycle-timeout watchdog, and a FIFO log of ordinary stores. Benches and FPGA builds read its status instead of scanning waveforms.

## Interface
Parameters:
- `XLEN`, 32: width of the address and data buses.
- `TOHOST_ADDR`, 32'd100: a store to this address ends the test.
- `PASS_DATA`, 32'd25: a tohost store carrying this value means pass. Any other value means fail.
- `TIMEOUT`, 500: the watchdog limit in cycles. 0 disables the watchdog.
- `LOG_DEPTH`, 8: number of store-log entries. Must be a power of two and at least 2.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `MemWrite` in 1: the core's store strobe.
- `DataAdr` in XLEN: the store address.
- `WriteData` in XLEN: the store data.
- `log_pop` in 1: pops the head of the log.
- `log_valid` out 1: the log is not empty.
- `log_adr` out XLEN: address field of the head entry.
- `log_data` out XLEN: data field of the head entry.
- `log_overflow` out 1: sticky. Set when a store was dropped because the log was full.
- `state` out 2: current `mon_state_t` value.
- `done` out 1: `state` is not RUN.
- `cycle_count` out 32: cycles spent in RUN.
- `store_count` out 32: number of non-tohost stores accepted.

## Operation
- FSM states:
  - RUN (2'b00) is the reset state.
  - PASS (2'b01), FAIL (2'b10) and TIMEOUT (2'b11) are terminal. Only `reset` leaves them.
- A store is a rising edge of `clk` with `MemWrite`=1.
- Tohost store (`DataAdr`==`TOHOST_ADDR`) while in RUN:
  - Next state is PASS if `WriteData`==`PASS_DATA`, otherwise FAIL.
  - The store is not logged and not counted.
- Other store while in RUN:
  - `store_count` increments and wraps modulo 2^32.
  - The store {`DataAdr`, `WriteData`} is pushed into the log.
- Watchdog:
  - In RUN, `cycle_count` increments every edge and wraps when `TIMEOUT`=0.
  - If `TIMEOUT`≠0 and `cycle_count`==`TIMEOUT`-1 with no tohost store that cycle, next state is TIMEOUT.
  - A tohost store in that same cycle wins.
- In terminal states:
  - `cycle_count` and `store_count` freeze.
  - Stores are ignored.
  - `log_pop` still works, so the log can be drained after the test.
- Log behaviour:
  - Push when full: the entry is dropped and `log_overflow` is set, and `store_count` still increments. Exception: if a push and a pop happen in the same cycle while full, both take effect and no overflow occurs.
  - Pop when empty: ignored.
  - Push and pop when empty: the pop is ignored and the entry is written.
- The comparisons use full XLEN-bit equality. There is no byte masking.

## Timing
- Reset values: `state`=RUN, `done`=0, both counters 0, `log_valid`=0, `log_overflow`=0. `log_adr`/`log_data` are don't-care while `log_valid`=0. The log pointers are cleared.
- Latency:
  - A store at edge N updates `state`/`done`, the counters and `log_valid` visibly after edge N.
  - The log is first-word-fall-through: the head fields are valid in the same cycle `log_valid` is 1.
- All outputs are driven from registers or from the log array at the read pointer. There is no combinational path from inputs to outputs.
- Reset asserted mid-test clears the log contents and statistics immediately and asynchronously. Operation resumes on the first edge after deassertion.

## Structure
- Shared package `riscv_test_pkg` holds:
  - `typedef enum logic [1:0] mon_state_t` {MON_RUN, MON_PASS, MON_FAIL, MON_TIMEOUT}.
  - `typedef struct packed store_rec_t` {adr, data}, with XLEN 32 fixed in the package.
- Sub-module `sync_fifo`:
  - Parametrised by `WIDTH` and `DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Pointers carry one extra wrap bit.
  - Holds the `store_rec_t` log.
- The top contains the FSM, counters, overflow flag and tohost decode.
- Instantiated alongside `riscvsc_top` in the bench. Its outputs replace the fixed `#10000` stop.

## Test plan
- Reset, then stores of 7→84, 25→100 → `log_valid`=1 with head {84,7}, `store_count`=1, `state`=PASS, `done`=1.
- Reset, then a store of 26→100 → `state`=FAIL. A later 1→200 store is ignored: `store_count` stays 0 and `log_valid`=0.
- `TIMEOUT`=20, no stores → `state`=TIMEOUT after exactly 20 edges, `cycle_count` frozen at 20.
- `TIMEOUT`=20, a 25→100 store on the edge where `cycle_count`=19 → PASS, not TIMEOUT.
- `LOG_DEPTH`=4, six stores (adr 0,4,…,20), no pops → `log_overflow`=1, `store_count`=6. Popping yields adr 0,4,8,12, then `log_valid`=0. Repeat with the log full and a simultaneous push+pop → `log_overflow` stays 0.
- Assert `reset` mid-run after 3 logged stores → all outputs return to their reset values asynchronously, then counting resumes from 0.
